// File: rtl/cpu_isa_pkg.sv
// ISA field widths, opcode encoding and decoded-field helpers shared by the decode stage.
package cpu_isa_pkg;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP = 4'h0, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
    OPC_SHL, OPC_SHR, OPC_LDI, OPC_LD, OPC_ST, OPC_BR
  } opcode_e;

  localparam logic [OPC_W-1:0] ILLEGAL_OPC_MIN = 4'hC;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [IMM_W-1:0] imm;
  } dec_fields_t;

  function automatic dec_fields_t split_instr(input logic [INSTR_W-1:0] w);
    dec_fields_t f;
    f.opcode = w[15:12];
    f.rd     = w[11:8];
    f.rs     = w[7:4];
    f.rt     = w[3:0];
    f.imm    = w[7:0];
    return f;
  endfunction

  function automatic logic is_reserved(input logic [OPC_W-1:0] opc);
    return opc >= ILLEGAL_OPC_MIN;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// Circular FIFO with naturally wrapping pointers; push when full and pop when empty are ignored.
module instr_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared too so the decoded fields read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_decode_stage.sv
// 4-phase req/ack capture into a FIFO with ISA field split on the head entry.
// Optional ILLEGAL_TRAP_EN: reserved opcodes are acknowledged but dropped, raising sticky trap_flag.
module instr_decode_stage
  import cpu_isa_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_req,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               instr_ack,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [OPC_W-1:0]   dec_opcode,
  output logic [REG_W-1:0]   dec_rd,
  output logic [REG_W-1:0]   dec_rs,
  output logic [REG_W-1:0]   dec_rt,
  output logic [IMM_W-1:0]   dec_imm,
  output logic               dec_illegal,
  output logic               fifo_full
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               trap_flag
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ACK_HI, ACK_LO} state_t;

  state_t             state, state_next;
  logic [SYNC_STAGES-1:0] req_sync;
  logic               req_s;
  logic               capture;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] head;
  dec_fields_t        fields;

  // Only the request crosses domains; data is held stable by the bundled-data protocol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_sync <= '0;
    else     req_sync <= {req_sync[SYNC_STAGES-2:0], instr_req};
  end
  assign req_s = req_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && !full) begin
          capture    = 1'b1;
          state_next = ACK_HI;
        end
      end
      ACK_HI:  if (!req_s) state_next = ACK_LO;
      ACK_LO:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign instr_ack = (state == ACK_HI);
  assign pop       = dec_valid && dec_ready;

`ifdef ILLEGAL_TRAP_EN
  assign push        = capture && !is_reserved(instr_data[15:12]);
  assign dec_illegal = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           trap_flag <= 1'b0;
    else if (capture && is_reserved(instr_data[15:12])) trap_flag <= 1'b1;
  end
`else
  assign push        = capture;
  assign dec_illegal = is_reserved(fields.opcode);
`endif

  instr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (instr_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  assign fields     = split_instr(head);
  assign dec_valid  = !empty;
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign dec_opcode = fields.opcode;
  assign dec_rd     = fields.rd;
  assign dec_rs     = fields.rs;
  assign dec_rt     = fields.rt;
  assign dec_imm    = fields.imm;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized and directed bench for instr_decode_stage with a queue scoreboard and field model.
module tb_instr_decode_stage;
  localparam int SYNC = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0;
  logic [15:0] instr_data = '0;
  logic        instr_ack;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_opcode, dec_rd, dec_rs, dec_rt;
  logic [7:0]  dec_imm;
  logic        dec_illegal;
  logic        fifo_full;
`ifdef ILLEGAL_TRAP_EN
  logic        trap_flag;
  logic        exp_trap = 1'b0;
`endif

  logic        rdy_rand = 1'b0;
  logic        rdy_fix  = 1'b0;
  logic        rnd_bit  = 1'b0;
  assign dec_ready = rdy_rand ? rnd_bit : rdy_fix;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          pops = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_w;

  always #5 clk = ~clk;

  instr_decode_stage #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_req   (instr_req),
    .instr_data  (instr_data),
    .instr_ack   (instr_ack),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_opcode  (dec_opcode),
    .dec_rd      (dec_rd),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_imm     (dec_imm),
    .dec_illegal (dec_illegal),
`ifdef ILLEGAL_TRAP_EN
    .trap_flag   (trap_flag),
`endif
    .fifo_full   (fifo_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: every accepted head is compared against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("extra_pop", 32'(dec_opcode), 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_q.pop_front();
        check("opcode", 32'(dec_opcode), 32'(mon_w) / 4096);
        check("rd", 32'(dec_rd), (32'(mon_w) / 256) % 16);
        check("rs", 32'(dec_rs), (32'(mon_w) / 16) % 16);
        check("rt", 32'(dec_rt), 32'(mon_w) % 16);
        check("imm", 32'(dec_imm), 32'(mon_w) % 256);
`ifdef ILLEGAL_TRAP_EN
        check("illegal", 32'(dec_illegal), 0);
`else
        check("illegal", 32'(dec_illegal), 32'((32'(mon_w) / 4096) >= 12));
`endif
      end
    end
  end

  task automatic model_push(input logic [15:0] w);
`ifdef ILLEGAL_TRAP_EN
    if ((32'(w) / 4096) >= 12) exp_trap = 1'b1;
    else exp_q.push_back(w);
`else
    exp_q.push_back(w);
`endif
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_ack === lvl) return;
    end
    check(name, 32'(instr_ack), 32'(lvl));
  endtask

  task automatic raise(input logic [15:0] w);
    wait_ack(1'b0, 200, "ack_idle");
    @(negedge clk);
    instr_data = w;
    instr_req  = 1'b1;
    model_push(w);
  endtask

  task automatic finish_hs();
    @(negedge clk);
    instr_req = 1'b0;
    wait_ack(1'b0, 200, "ack_fall");
    instr_data = 16'($urandom);
  endtask

  task automatic send(input logic [15:0] w);
    raise(w);
    wait_ack(1'b1, 400, "ack_rise");
    finish_hs();
  endtask

  task automatic drain(input int cycles);
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    repeat (cycles) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int cyc;
    int pops0;
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pops0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(instr_ack), 0);
    check("rst_valid", 32'(dec_valid), 0);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_fields", {dec_opcode, dec_rd, dec_rs, dec_rt, dec_imm}, 0);
    check("rst_illegal", 32'(dec_illegal), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single word and ack latency
    rdy_fix = 1'b1;
    pops0 = pops;
    @(negedge clk);
    instr_data = 16'h1234;
    instr_req  = 1'b1;
    model_push(16'h1234);
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!instr_ack && cyc < 50);
    check("ack_latency", cyc, SYNC + 1);
    finish_hs();
    repeat (4) @(negedge clk);
    check("single_pops", pops - pops0, 1);

    // Backpressure
    rdy_fix = 1'b0;
    send(16'h1001);
    send(16'h2002);
    @(negedge clk);
    check("full_flag", 32'(fifo_full), 1);
    raise(16'h3003);
    repeat (10) @(negedge clk);
    check("blocked_ack", 32'(instr_ack), 0);
    pops0 = pops;
    rdy_fix = 1'b1;
    wait_ack(1'b1, 50, "ack_after_pop");
    check("pop_before_ack", 32'(pops - pops0 >= 1), 1);
    finish_hs();
    drain(8);

    // Long req: one write, ack held, then released after sync delay
    raise(16'h7ABC);
    wait_ack(1'b1, 50, "long_ack");
    repeat (20) @(negedge clk);
    check("long_ack_hold", 32'(instr_ack), 1);
    instr_req = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (instr_ack && cyc < 50);
    check("ack_release", cyc, SYNC + 1);
    @(negedge clk);
    check("ack_low_after", 32'(instr_ack), 0);
    drain(8);

    // Illegal opcode
    rdy_fix = 1'b0;
    send(16'hE123);
    @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    check("trap_valid", 32'(dec_valid), 0);
    check("trap_flag", 32'(trap_flag), 1);
`else
    check("illegal_valid", 32'(dec_valid), 1);
    check("illegal_head", 32'(dec_illegal), 1);
`endif
    drain(6);

    // Randomized traffic with random consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) send(16'($urandom));
    drain(20);

    // Reset mid-handshake with two entries queued
    rdy_fix = 1'b0;
    send(16'h4444);
    raise(16'h5555);
    wait_ack(1'b1, 50, "pre_rst_ack");
    @(negedge clk);
    check("pre_rst_full", 32'(fifo_full), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(instr_ack), 0);
    check("mid_rst_valid", 32'(dec_valid), 0);
    check("mid_rst_full", 32'(fifo_full), 0);
    exp_q.delete();
    model_push(16'h5555);
    @(negedge clk);
    rst = 1'b0;
    pops0 = pops;
    wait_ack(1'b1, 50, "recapture_ack");
    finish_hs();
    drain(10);
    check("recapture_pops", pops - pops0, 1);
`ifdef ILLEGAL_TRAP_EN
    check("trap_cleared", 32'(trap_flag), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
